// File: rtl/spi_aes_pkg.sv
// spi_aes_pkg: state encoding, mode constants and width helpers shared by the
// SPI AES slave front-end and its testbench.
package spi_aes_pkg;

   localparam int unsigned MSG_W = 128;

   localparam logic ENCR = 1'b0;
   localparam logic DECR = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RX_MSG,
      RX_KEY,
      START,
      WAIT,
      TX,
      DONE
   } state_e;

   function automatic int unsigned keybits(input int unsigned nk);
      return nk * 32;
   endfunction

endpackage

// File: rtl/spi_aes_shreg.sv
// spi_aes_shreg: W-bit right-shift register with parallel load and serial input.
// The serial output is bit 0 of q; load takes priority over shift.
module spi_aes_shreg #(
   parameter int unsigned W = 128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic         sin,
   input  logic [W-1:0] din,
   output logic [W-1:0] q
);

   logic [W-1:0] data_q, data_d;

   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = din;
      end else if (shift) begin
         data_d = {sin, data_q[W-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/spi_aes_slave.sv
// spi_aes_slave: serial front-end that collects block + key, runs the external
// AES core via start/done and streams the result back LSB first.
// Optional key reuse (key_reuse port) is enabled by SPI_AES_KEY_REUSE_EN.
module spi_aes_slave
   import spi_aes_pkg::*;
#(
   parameter int unsigned NK = 4,
   parameter int unsigned NR = NK + 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cs_n,
   input  logic                   SIMO,
   input  logic                   mode,
`ifdef SPI_AES_KEY_REUSE_EN
   input  logic                   key_reuse,
`endif
   output logic                   SOMI,
   output logic                   core_start,
   output logic                   core_mode,
   output logic [MSG_W-1:0]       core_msg,
   output logic [keybits(NK)-1:0] core_key,
   input  logic                   core_done,
   input  logic [MSG_W-1:0]       core_result,
   output logic [MSG_W-1:0]       out,
   output logic                   result_valid,
   output logic                   busy,
   output logic                   frame_err
);

   localparam int unsigned KB = keybits(NK);
   localparam int unsigned CW = $clog2(MSG_W + KB);
   localparam logic [CW-1:0] MSG_LAST = CW'(MSG_W - 2);
   localparam logic [CW-1:0] KEY_LAST = CW'(KB - 1);
   localparam logic [CW-1:0] TX_LAST  = CW'(MSG_W - 1);

   if (!(NK == 4 || NK == 6 || NK == 8) || NR < 10 || NR > 14) begin : g_param_check
      $error("spi_aes_slave: NK must be 4, 6 or 8 and NR within 10..14");
   end

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mode_q, mode_d;
   logic [MSG_W-1:0] out_q, out_d;
   logic            start_q, start_d;
   logic            rv_q, rv_d;
   logic            ferr_q, ferr_d;
`ifdef SPI_AES_KEY_REUSE_EN
   logic            reuse_q, reuse_d;
`endif

   logic             msg_shift, key_shift, tx_load, tx_shift;
   logic [MSG_W-1:0] msg_par, tx_par;
   logic [KB-1:0]    key_par;

   spi_aes_shreg #(.W(MSG_W)) u_msg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (1'b0),
      .shift (msg_shift),
      .sin   (SIMO),
      .din   ('0),
      .q     (msg_par)
   );

   spi_aes_shreg #(.W(KB)) u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (1'b0),
      .shift (key_shift),
      .sin   (SIMO),
      .din   ('0),
      .q     (key_par)
   );

   spi_aes_shreg #(.W(MSG_W)) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tx_load),
      .shift (tx_shift),
      .sin   (1'b0),
      .din   (core_result),
      .q     (tx_par)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      mode_d    = mode_q;
      out_d     = out_q;
      rv_d      = 1'b0;
      ferr_d    = 1'b0;
      msg_shift = 1'b0;
      key_shift = 1'b0;
      tx_load   = 1'b0;
      tx_shift  = 1'b0;
`ifdef SPI_AES_KEY_REUSE_EN
      reuse_d   = reuse_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            // The first serial bit arrives together with the frame select edge.
            if (!cs_n) begin
               mode_d    = mode;
`ifdef SPI_AES_KEY_REUSE_EN
               reuse_d   = key_reuse;
`endif
               msg_shift = 1'b1;
               state_d   = RX_MSG;
            end
         end
         RX_MSG: begin
            if (cs_n) begin
               ferr_d  = 1'b1;
               state_d = IDLE;
            end else begin
               msg_shift = 1'b1;
               if (cnt_q == MSG_LAST) begin
`ifdef SPI_AES_KEY_REUSE_EN
                  state_d = reuse_q ? START : RX_KEY;
`else
                  state_d = RX_KEY;
`endif
               end
            end
         end
         RX_KEY: begin
            if (cs_n) begin
               ferr_d  = 1'b1;
               state_d = IDLE;
            end else begin
               key_shift = 1'b1;
               if (cnt_q == KEY_LAST) begin
                  state_d = START;
               end
            end
         end
         START: state_d = WAIT;
         WAIT: begin
            if (core_done) begin
               out_d   = core_result;
               tx_load = 1'b1;
               rv_d    = 1'b1;
               state_d = TX;
            end
         end
         TX: begin
            if (cs_n) begin
               ferr_d  = 1'b1;
               state_d = IDLE;
            end else begin
               tx_shift = 1'b1;
               if (cnt_q == TX_LAST) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (cs_n) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
         cnt_d = '0;
      end
      start_d = (state_d == START);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         out_q   <= '0;
         start_q <= 1'b0;
         rv_q    <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef SPI_AES_KEY_REUSE_EN
         reuse_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         out_q   <= out_d;
         start_q <= start_d;
         rv_q    <= rv_d;
         ferr_q  <= ferr_d;
`ifdef SPI_AES_KEY_REUSE_EN
         reuse_q <= reuse_d;
`endif
      end
   end

   assign SOMI         = (state_q == TX) && tx_par[0];
   assign core_start   = start_q;
   assign core_mode    = mode_q;
   assign core_msg     = msg_par;
   assign core_key     = key_par;
   assign out          = out_q;
   assign result_valid = rv_q;
   assign busy         = (state_q != IDLE);
   assign frame_err    = ferr_q;

endmodule

// File: doc/spi_aes_slave.md
Name: spi_aes_slave

Overview:
Parametrised serial front-end for the AES engine. It receives a 128-bit block and an NK*32-bit key over a single-wire SIMO stream framed by cs_n, and hands them to the external cipher/inverse-cipher core through a start/done handshake. It then shifts the 128-bit result back out on SOMI. Successor to the fixed encrypt-only serial slave: it adds selectable key size, decrypt mode, framing, abort handling and a core handshake.

Parameters:
NK, 4, key length in 32-bit words (4/6/8 = AES-128/192/256); any other value is a compile-time error.
NR, NK+6, round count forwarded to the core.
MSG_W, 128, block width; fixed by AES, exposed only for the package.

Ports:
clk  in  1  system clock; SIMO is sampled and SOMI updated on its rising edge.
rst_n  in  1  synchronous active-low reset.
cs_n  in  1  frame select, active low; one serial bit per clk while low.
SIMO  in  1  serial data in, LSB first.
mode  in  1  0 = encrypt, 1 = decrypt; sampled on the first cycle cs_n is low.
SOMI  out  1  serial result out, LSB first.
core_start  out  1  one-cycle pulse launching the core.
core_mode  out  1  registered frame mode.
core_msg  out  128  captured block.
core_key  out  NK*32  captured key.
core_done  in  1  one-cycle pulse from the core; core_result is valid in the same cycle.
core_result  in  128  core output.
out  out  128  last result, held until the next result.
result_valid  out  1  one-cycle pulse when out updates.
busy  out  1  high in any state other than IDLE.
frame_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs, msg, key and bit counter cleared to 0. Reset overrides everything, including a mid-frame transfer or an outstanding core_done.
- Bit counter width is $clog2(MSG_W+NK*32); it resets to 0 on each state entry.
- IDLE: when cs_n=0, latch mode and capture SIMO as message bit 0 in the same cycle, then go to RX_MSG.
- RX_MSG: shift right, msg <= {SIMO, msg[127:1]}. After 128 bits total, go to RX_KEY.
- RX_KEY: key <= {SIMO, key[NK*32-1:1]}. On the last of NK*32 bits, go to START.
- START: core_start=1 for one cycle; core_msg, core_key and core_mode are stable from here until core_done. Then go to WAIT.
- WAIT: SIMO is ignored; cs_n may stay low. On core_done: latch core_result into out and a TX shift register, pulse result_valid, go to TX.
- TX: SOMI = txreg[0], starting the cycle after core_done; shift right each clk while cs_n=0. After 128 bits, SOMI=0 and go to DONE.
- DONE: wait for cs_n=1, then go to IDLE. A new frame therefore requires cs_n to be high for at least one cycle.
- Abort: cs_n=1 in RX_MSG, RX_KEY or TX pulses frame_err and returns to IDLE, with SOMI=0 and no core_start.
  - In TX, out remains valid.
  - cs_n=1 in START or WAIT is not an abort; the state machine continues.
- core_done outside WAIT is ignored.
- Total frame length: 128 + NK*32 + 1 + core latency + 128 cycles.

Optional Feature:
SPI_AES_KEY_REUSE_EN:
- With the macro defined, an extra input key_reuse (1 bit) is sampled together with mode. If key_reuse=1, RX_KEY is skipped: after 128 message bits the state goes straight to START using the stored key. The stored key is zero after reset.
- Without the macro, the port is absent and every frame carries a key.

Decomposition:
- Package spi_aes_pkg: state enum (IDLE, RX_MSG, RX_KEY, START, WAIT, TX, DONE), constants ENCR=1'b0 and DECR=1'b1, MSG_W=128, and a function keybits(NK)=NK*32.
- One sub-module, spi_aes_shreg: a parametric width-W right-shift register with load, shift and serial in/out. It is instantiated three times: msg, key and tx.

Test Plan:
1. NK=4, encrypt: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, core model with 3-cycle latency -> core_start one cycle after the 256th bit; out=69c4e0d86a7b0430d8cdb78070b4c55a; SOMI carries it LSB first across 128 cycles.
2. NK=4, decrypt of the case-1 ciphertext with the same key -> core_mode=1 and out=00112233445566778899aabbccddeeff.
3. NK=8, key 000102..1f, pt 00112233..ff -> 384 receive bits, out=8ea2b7ca516745bfeafc49904b496089.
4. cs_n raised after 100 message bits -> frame_err pulses, no core_start, busy=0 next cycle; the next full frame behaves as in case 1.
5. rst_n low during TX -> SOMI=0, out=0, state IDLE; core_done arriving afterwards is ignored.
6. With SPI_AES_KEY_REUSE_EN: run case 1, then a frame with key_reuse=1 and 128 bits only -> same key used and ciphertext correct.
